// File: rtl/mem_ls_pkg.sv
// Shared definitions for the load/store memory access sequencer:
// operation encodings, FSM state encoding and alignment helpers.
package mem_ls_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;

  // Halfword accesses need an even address, word accesses a multiple of four.
  function automatic logic is_misaligned(op_e op, logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return off != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(op_e op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

endpackage

// File: rtl/ls_lane_unit.sv
// Little-endian byte/half lane handling: extracts and extends the addressed
// lane of a read word for loads, and merges store data into a read word.
module ls_lane_unit
  import mem_ls_pkg::*;
(
  input  op_e         op_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_val_o,
  output logic [31:0] store_word_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign byte_sh = {byte_off_i, 3'b000};
  assign half_sh = {byte_off_i[1], 4'b0000};
  assign lane_b  = 8'(rd_word_i >> byte_sh);
  assign lane_h  = 16'(rd_word_i >> half_sh);

  // Select the load result and the merged store word for the current op.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    load_val_o   = rd_word_i;
    store_word_o = rd_word_i;
    case (op_i)
      OP_LB:  load_val_o = {{24{lane_b[7]}}, lane_b};
      OP_LBU: load_val_o = {24'd0, lane_b};
      OP_LH:  load_val_o = {{16{lane_h[15]}}, lane_h};
      OP_LHU: load_val_o = {16'd0, lane_h};
      OP_LW:  load_val_o = rd_word_i;
      OP_SB:  store_word_o = (rd_word_i & ~(32'h0000_00FF << byte_sh))
                           | ({24'd0, wdata_i[7:0]} << byte_sh);
      OP_SH:  store_word_o = (rd_word_i & ~(32'h0000_FFFF << half_sh))
                           | ({16'd0, wdata_i[15:0]} << half_sh);
      OP_SW:  store_word_o = wdata_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_seq.sv
// Memory access sequencer: accepts one byte/half/word load or store at a
// time, performs read-modify-write for sub-word stores, and reports
// completion with a one-cycle done pulse (err flags misaligned requests).
module mem_access_seq
  import mem_ls_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e             state_q;
  logic               pend_q;     // request latched, decode on next edge
  op_e                op_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ready_q;
  logic               done_q;
  logic               err_q;
  logic [31:0]        rdata_q;
  logic [31:0]        mem_addr_q;
  logic               mem_wr_q;
  logic [31:0]        mem_wdata_q;

  logic [31:0]        load_val_d;
  logic [31:0]        store_word_d;
  logic [31:0]        word_addr_d;

  assign word_addr_d = {addr_q[31:2], 2'b00};

  // Lane logic always works on the live memory word: it is sampled on the
  // last WAIT edge, which is exactly when rdata / mem_wdata get loaded.
  ls_lane_unit u_lane (
    .op_i        (op_q),
    .byte_off_i  (addr_q[1:0]),
    .rd_word_i   (mem_rdata),
    .wdata_i     (wdata_q),
    .load_val_o  (load_val_d),
    .store_word_o(store_word_d)
  );

  // Sequencer FSM with all interface outputs registered.
  always_ff @(posedge clock) begin
    // NOTE: only the control/interface registers are reset; there is no
    // storage array here, so every register has a defined reset value.
    if (reset) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      op_q        <= OP_LB;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge state; later lines below override these pulse defaults.
      done_q   <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!pend_q) begin
            if (req) begin
              op_q    <= op_e'(op);
              addr_q  <= addr;
              wdata_q <= wdata;
              pend_q  <= 1'b1;
              ready_q <= 1'b0;
            end
          end else begin
            pend_q <= 1'b0;
            if (is_misaligned(op_q, addr_q[1:0])) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (op_q == OP_SW) begin
              state_q     <= ST_WRITE;
              mem_addr_q  <= word_addr_d;
              mem_wr_q    <= 1'b1;
              mem_wdata_q <= store_word_d;
            end else begin
              state_q    <= ST_READ;
              mem_addr_q <= word_addr_d;
            end
          end
        end
        ST_READ: begin
          state_q <= ST_WAIT;
          cnt_q   <= CNT_W'(MEM_LAT - 1);
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            if (is_store(op_q)) begin
              state_q     <= ST_WRITE;
              mem_wr_q    <= 1'b1;
              mem_wdata_q <= store_word_d;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b0;
              rdata_q <= load_val_d;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_WRITE: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
          err_q   <= 1'b0;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          pend_q  <= 1'b0;
          ready_q <= 1'b1;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: two instances (read latency 1 and 3) with a
// behavioural memory each, checked cycle by cycle against a reference
// model of the access rules.
module tb_mem_access_seq;

  localparam int LB = 0, LBU = 1, LH = 2, LHU = 3, LW = 4, SB = 5, SH = 6, SW = 7;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_s       [2];
  logic [2:0]  op_s        [2];
  logic [31:0] addr_s      [2];
  logic [31:0] wdata_s     [2];
  logic        ready_s     [2];
  logic        done_s      [2];
  logic        err_s       [2];
  logic [31:0] rdata_s     [2];
  logic [31:0] mem_addr_s  [2];
  logic        mem_wr_s    [2];
  logic [31:0] mem_wdata_s [2];
  logic [31:0] mem_rdata_s [2];

  logic [31:0] mem   [2][256];
  logic [31:0] apipe [2][4];
  logic [31:0] exp_rdata [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_access_seq #(.MEM_LAT(1)) dut0 (
    .clock(clock), .reset(reset), .req(req_s[0]), .op(op_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .ready(ready_s[0]),
    .done(done_s[0]), .err(err_s[0]), .rdata(rdata_s[0]),
    .mem_addr(mem_addr_s[0]), .mem_wr(mem_wr_s[0]),
    .mem_wdata(mem_wdata_s[0]), .mem_rdata(mem_rdata_s[0])
  );

  mem_access_seq #(.MEM_LAT(3)) dut1 (
    .clock(clock), .reset(reset), .req(req_s[1]), .op(op_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .ready(ready_s[1]),
    .done(done_s[1]), .err(err_s[1]), .rdata(rdata_s[1]),
    .mem_addr(mem_addr_s[1]), .mem_wr(mem_wr_s[1]),
    .mem_wdata(mem_wdata_s[1]), .mem_rdata(mem_rdata_s[1])
  );

  // Memory: read data appears MEM_LAT cycles after the address is
  // presented; writes land on the strobe edge.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 3; j > 0; j--) apipe[i][j] <= apipe[i][j-1];
      apipe[i][0] <= mem_addr_s[i];
      if (mem_wr_s[i]) mem[i][mem_addr_s[i][9:2]] = mem_wdata_s[i];
    end
  end

  assign mem_rdata_s[0] = mem[0][apipe[0][0][9:2]];
  assign mem_rdata_s[1] = mem[1][apipe[1][2][9:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int lat_of(input int inst);
    return (inst == 0) ? 1 : 3;
  endfunction

  function automatic bit mis(input int op, input logic [31:0] a);
    if (op == LH || op == LHU || op == SH) return a[0];
    if (op == LW || op == SW) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic int lat_model(input int inst, input int op, input logic [31:0] a);
    if (mis(op, a)) return 1;
    if (op == SW) return 2;
    if (op == SB || op == SH) return 3 + lat_of(inst);
    return 2 + lat_of(inst);
  endfunction

  function automatic logic [31:0] load_model(input int op, input logic [31:0] a,
                                             input logic [31:0] word);
    logic [31:0] s;
    logic [31:0] h;
    byte         b;
    shortint     hw;
    s  = word >> (8 * int'(a[1:0]));
    h  = word >> (16 * int'(a[1]));
    b  = s[7:0];
    hw = h[15:0];
    case (op)
      LB:      return 32'(int'(b));
      LBU:     return 32'(s[7:0]);
      LH:      return 32'(int'(hw));
      LHU:     return 32'(h[15:0]);
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_model(input int op, input logic [31:0] a,
                                              input logic [31:0] word, input logic [31:0] wd);
    logic [7:0] by [4];
    for (int i = 0; i < 4; i++) by[i] = word[8*i +: 8];
    if (op == SW) return wd;
    if (op == SB) by[a[1:0]] = wd[7:0];
    if (op == SH) begin
      by[{a[1], 1'b0}] = wd[7:0];
      by[{a[1], 1'b1}] = wd[15:8];
    end
    return {by[3], by[2], by[1], by[0]};
  endfunction

  // One access on instance inst, checked on every cycle until back in IDLE.
  task automatic run_access(input int inst, input int op, input logic [31:0] a,
                            input logic [31:0] wd, input bit junk, output int done_at);
    int          lat, wc, L;
    bit          m, accepted;
    logic [31:0] word_before, exp_new, exp_store, old_rd, waddr;
    L           = lat_of(inst);
    m           = mis(op, a);
    lat         = lat_model(inst, op, a);
    word_before = mem[inst][a[9:2]];
    old_rd      = exp_rdata[inst];
    exp_new     = (!m && op <= LW) ? load_model(op, a, word_before) : old_rd;
    exp_store   = store_model(op, a, word_before, wd);
    wc          = m ? 0 : (op == SW ? 1 : (op >= SB ? 2 + L : 0));
    waddr       = {a[31:2], 2'b00};
    done_at     = -1;

    @(negedge clock);
    req_s[inst] = 1'b1; op_s[inst] = 3'(op); addr_s[inst] = a; wdata_s[inst] = wd;
    accepted = 0;
    for (int t = 0; t < 20 && !accepted; t++) begin
      if (ready_s[inst]) accepted = 1;
      else @(negedge clock);
    end
    if (!accepted) begin
      check("ready_timeout", 32'(ready_s[inst]), 32'd1);
      req_s[inst] = 1'b0;
      return;
    end
    @(posedge clock); #1;
    req_s[inst] = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      if (junk) begin
        req_s[inst] = 1'($urandom); op_s[inst] = 3'($urandom);
        addr_s[inst] = $urandom; wdata_s[inst] = $urandom;
      end
      @(posedge clock); #1;
      check($sformatf("done i%0d op%0d k%0d", inst, op, k), 32'(done_s[inst]), 32'(k == lat));
      if (k == lat) check($sformatf("err i%0d op%0d", inst, op), 32'(err_s[inst]), 32'(m));
      check($sformatf("ready i%0d op%0d k%0d", inst, op, k), 32'(ready_s[inst]), 32'(k == lat + 1));
      check($sformatf("mem_wr i%0d op%0d k%0d", inst, op, k), 32'(mem_wr_s[inst]), 32'(k == wc));
      if (k == 1 && !m) check($sformatf("mem_addr i%0d op%0d", inst, op), mem_addr_s[inst], waddr);
      if (k == wc) check($sformatf("mem_wdata i%0d op%0d", inst, op), mem_wdata_s[inst], exp_store);
      check($sformatf("rdata i%0d op%0d k%0d", inst, op, k), rdata_s[inst],
            (k >= lat) ? exp_new : old_rd);
      if (done_s[inst] && done_at < 0) done_at = k;
    end
    req_s[inst] = 1'b0;
    exp_rdata[inst] = exp_new;
    if (wc != 0) check($sformatf("mem_word i%0d op%0d", inst, op), mem[inst][a[9:2]], exp_store);
  endtask

  task automatic check_reset_values(input int inst);
    check($sformatf("rst ready i%0d", inst), 32'(ready_s[inst]), 32'd1);
    check($sformatf("rst done i%0d", inst), 32'(done_s[inst]), 32'd0);
    check($sformatf("rst err i%0d", inst), 32'(err_s[inst]), 32'd0);
    check($sformatf("rst mem_wr i%0d", inst), 32'(mem_wr_s[inst]), 32'd0);
    check($sformatf("rst rdata i%0d", inst), rdata_s[inst], 32'd0);
    check($sformatf("rst mem_addr i%0d", inst), mem_addr_s[inst], 32'd0);
    check($sformatf("rst mem_wdata i%0d", inst), mem_wdata_s[inst], 32'd0);
  endtask

  task automatic random_accesses(input int count);
    int d;
    for (int n = 0; n < count; n++) begin
      run_access(int'($urandom_range(1, 0)), int'($urandom_range(7, 0)),
                 32'($urandom_range(32'h3FF, 0)), $urandom, 1'($urandom), d);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          d;
    int          ndone;
    logic [31:0] snap;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b0; op_s[i] = '0; addr_s[i] = '0; wdata_s[i] = '0;
      exp_rdata[i] = '0;
      for (int j = 0; j < 4; j++) apipe[i][j] = '0;
      for (int w = 0; w < 256; w++) mem[i][w] = $urandom;
    end
    repeat (2) @(posedge clock);
    #1;
    check_reset_values(0);
    check_reset_values(1);
    @(negedge clock);
    reset = 1'b0;

    // Directed cases with hand-computed results (latency 1 instance).
    mem[0][8'h40] = 32'h80FF1234;
    run_access(0, LB, 32'h103, 32'h0, 1'b0, d);
    check("lb done cycle", 32'(d), 32'd3);
    check("lb rdata", rdata_s[0], 32'hFFFFFF80);
    check("lb mem_addr", mem_addr_s[0], 32'h100);
    run_access(0, LHU, 32'h102, 32'h0, 1'b0, d);
    check("lhu rdata", rdata_s[0], 32'h000080FF);
    run_access(0, LH, 32'h102, 32'h0, 1'b1, d);
    check("lh rdata", rdata_s[0], 32'hFFFF80FF);
    mem[0][8'h40] = 32'h11223344;
    run_access(0, SB, 32'h101, 32'h000000AB, 1'b0, d);
    check("sb done cycle", 32'(d), 32'd4);
    check("sb mem word", mem[0][8'h40], 32'h1122AB44);
    run_access(0, LW, 32'h102, 32'h0, 1'b0, d);
    check("lw misaligned done cycle", 32'(d), 32'd1);
    check("lw misaligned rdata held", rdata_s[0], 32'hFFFF80FF);

    // Latency 3, LW with req held high: one access, then a second accepted
    // only after the return to IDLE.
    mem[1][8'h80] = 32'hCAFE0001;
    @(negedge clock);
    req_s[1] = 1'b1; op_s[1] = 3'(LW); addr_s[1] = 32'h200; wdata_s[1] = 32'h0;
    check("hold ready before", 32'(ready_s[1]), 32'd1);
    @(posedge clock); #1;
    ndone = 0;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clock); #1;
      check($sformatf("hold done k%0d", k), 32'(done_s[1]), 32'(k == 5 || k == 12));
      check($sformatf("hold ready k%0d", k), 32'(ready_s[1]), 32'(k == 6 || k == 13));
      check($sformatf("hold mem_wr k%0d", k), 32'(mem_wr_s[1]), 32'd0);
      if (k <= 6) ndone += int'(done_s[1]);
      if (k == 5) check("hold rdata", rdata_s[1], 32'hCAFE0001);
      if (k == 7) req_s[1] = 1'b0;
    end
    check("hold single done", 32'(ndone), 32'd1);
    exp_rdata[1] = 32'hCAFE0001;

    random_accesses(150);

    // SH abandoned by reset while waiting for read data.
    snap = mem[0][8'h40];
    @(negedge clock);
    req_s[0] = 1'b1; op_s[0] = 3'(SH); addr_s[0] = 32'h102; wdata_s[0] = 32'h0000BEEF;
    @(posedge clock); #1;
    req_s[0] = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
    end
    check("abort mem_wr before", 32'(mem_wr_s[0]), 32'd0);
    reset = 1'b1;
    req_s[0] = 1'b1;
    req_s[1] = 1'b1;
    @(posedge clock); #1;
    check_reset_values(0);
    check_reset_values(1);
    @(posedge clock); #1;
    check("reset beats req i0", 32'(ready_s[0]), 32'd1);
    check("reset beats req i1", 32'(ready_s[1]), 32'd1);
    reset = 1'b0;
    req_s[0] = 1'b0;
    req_s[1] = 1'b0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      check($sformatf("abort done k%0d", k), 32'(done_s[0]), 32'd0);
      check($sformatf("abort mem_wr k%0d", k), 32'(mem_wr_s[0]), 32'd0);
    end
    check("abort mem untouched", mem[0][8'h40], snap);

    random_accesses(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, memory read latency in cycles (address presented to mem_rdata valid); legal range 1..7.
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  1  access request, sampled only while ready=1.
REQ-005 SHALL have port op  input  3  0=LB, 1=LBU, 2=LH, 3=LHU, 4=LW, 5=SB, 6=SH, 7=SW.
REQ-006 SHALL have port addr  input  32  byte address.
REQ-007 SHALL have port wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 SHALL have port ready  output  1  high only in IDLE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port err  output  1  valid with done; misaligned access.
REQ-011 SHALL have port rdata  output  32  extended load result, held until the next successful load completes.
REQ-012 SHALL have port mem_addr  output  32  word address, bits [1:0] always 0.
REQ-013 SHALL have port mem_wr  output  1  write strobe, one cycle per store.
REQ-014 SHALL have port mem_wdata  output  32  full word to write.
REQ-015 SHALL have port mem_rdata  input  32  memory read word.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WAIT, WRITE, DONE.
REQ-017 SHALL, on req=1 in IDLE, register op, addr and wdata, then leave IDLE on the next cycle.
REQ-018 SHALL decode the transition out of IDLE as: misaligned access -> DONE; SW -> WRITE; all others -> READ.
REQ-019 SHALL treat LH, LHU and SH with addr[0]=1 as misaligned, and LW and SW with addr[1:0]!=0 as misaligned.
REQ-020 SHALL, for a misaligned access, make no memory access (mem_wr stays 0) and pulse done=1 with err=1.
REQ-021 SHALL, in READ, drive mem_addr={addr[31:2],2'b00} and mem_wr=0 for one cycle, then enter WAIT.
REQ-022 SHALL remain in WAIT for MEM_LAT cycles using a down-counter, and capture mem_rdata in the last WAIT cycle.
REQ-023 SHALL, after WAIT, go to DONE for loads and to WRITE for SB/SH.
REQ-024 SHALL use little-endian byte lanes: addr[1:0]=n selects bits [8n+7:8n]; addr[1]=h selects half [16h+15:16h].
REQ-025 SHALL, for loads, sign-extend the selected lane for LB/LH, zero-extend it for LBU/LHU, and pass the word for LW.
REQ-026 SHALL, in WRITE, assert mem_wr=1 with the aligned mem_addr for exactly one cycle; mem_wdata = wdata for SW, otherwise the read word with only the selected lane replaced by wdata[7:0] or wdata[15:0].
REQ-027 SHALL, in DONE, pulse done=1 with err valid, update rdata for a successful load, and return to IDLE next cycle.
REQ-028 SHALL meet these latencies from the accept edge to done: LW/LB/LBU/LH/LHU 2+MEM_LAT; SW 2; SB/SH 3+MEM_LAT; misaligned 1.
REQ-029 SHALL ignore req whenever ready=0, with no queuing and no effect on the access in progress.
REQ-030 SHALL drive mem_wr=0 in every state except WRITE.

Reset
REQ-031 SHALL, on reset=1 at a clock edge, enter IDLE regardless of state (including mid-WAIT or WRITE) and abandon the access without done.
REQ-032 SHALL have these values after reset: ready=1; done=0, err=0, mem_wr=0; rdata, mem_addr, mem_wdata and wait counter = 0.
REQ-033 SHALL let reset override a simultaneous req.

Structure
REQ-034 SHALL take op encodings and FSM state encodings from shared package mem_ls_pkg.
REQ-035 SHALL place the combinational lane extract/extend/merge logic in sub-module ls_lane_unit, instantiated once.

Verification
REQ-036 SHALL cover, with MEM_LAT=1: LB at addr 0x103 with memory word 0x80FF1234 at 0x100 -> mem_addr=0x100, done at cycle 3, rdata=0xFFFFFF80, err=0.
REQ-037 SHALL cover: LHU at addr 0x102 with memory word 0x80FF1234 -> rdata=0x000080FF; LH at the same address -> rdata=0xFFFF80FF.
REQ-038 SHALL cover: SB at addr 0x101, wdata 0x000000AB, memory word 0x11223344 -> single mem_wr cycle with mem_wdata=0x1122AB44, done at cycle 4.
REQ-039 SHALL cover: LW at addr 0x102 -> done and err=1 at cycle 1, no mem_wr, rdata unchanged.
REQ-040 SHALL cover: SH issued, reset asserted during WAIT -> ready=1 next cycle, no mem_wr, no done.
REQ-041 SHALL cover: MEM_LAT=3, LW at 0x200 with req held high throughout -> done at cycle 5, exactly one access, second request accepted only after returning to IDLE.
